// File: rtl/imem_fetch_ctrl.sv
// Dual-wide instruction fetch sequencer: owns the PC, issues two imem reads per cycle, queues returns for dispatch.
// Latency: issue to dispatch 2 cycles; backpressure via occupancy-based issue throttle. Optional halt: IMEM_FETCH_HALT_EN.
module imem_fetch_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [ADDR_W-1:0]          imem_addr1,
    output logic [ADDR_W-1:0]          imem_addr2,
    input  logic [DATA_W-1:0]          imem_data1,
    input  logic [DATA_W-1:0]          imem_data2,
    output logic                       deq_valid0,
    output logic                       deq_valid1,
    output logic [DATA_W-1:0]          deq_inst0,
    output logic [DATA_W-1:0]          deq_inst1,
    output logic [ADDR_W-1:0]          deq_pc0,
    output logic [ADDR_W-1:0]          deq_pc1,
    input  logic [1:0]                 deq_count,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              inflight_q, inflight_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mpc_q [DEPTH];

    logic              ret_ok, halt1, halt2, halt_hit, issue;
    logic [1:0]        enq_n, deq_n, avail2;
    logic [CW:0]       need_w;

    assign imem_addr1 = pc_q;
    assign imem_addr2 = pc_q + ADDR_W'(1);

`ifdef IMEM_FETCH_HALT_EN
    assign halt1  = (imem_data1 == {DATA_W{1'b1}});
    assign halt2  = (imem_data2 == {DATA_W{1'b1}});
    assign halted = (state_q == S_HALT);
`else
    assign halt1  = 1'b0;
    assign halt2  = 1'b0;
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fpc_d      = fpc_q;
        inflight_d = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        enq_n      = 2'd0;
        deq_n      = 2'd0;

        ret_ok   = inflight_q && !redirect;
        halt_hit = ret_ok && (halt1 || halt2);
        if (ret_ok) begin
            // A halt in the first slot makes the second word younger, so it is dropped.
            enq_n = halt1 ? 2'd1 : 2'd2;
        end

        avail2 = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        if (!redirect) begin
            deq_n = (deq_count > avail2) ? avail2 : deq_count;
        end

        need_w = {1'b0, count_q} + {{(CW-1){1'b0}}, inflight_q, 1'b0};
        issue  = (state_q == S_FETCH) && fetch_en && !redirect && !halt_hit &&
                 (need_w <= (CW+1)'(DEPTH - 2));

        case (state_q)
            S_IDLE:  if (fetch_en) state_d = S_FETCH;
            S_FETCH: if (!fetch_en) state_d = S_IDLE;
            S_HALT:  if (redirect) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
        if (halt_hit) state_d = S_HALT;

        if (issue) begin
            pc_d       = pc_q + ADDR_W'(2);
            fpc_d      = pc_q;
            inflight_d = 1'b1;
        end

        head_d  = head_q + PW'(deq_n);
        tail_d  = tail_q + PW'(enq_n);
        count_d = count_q + CW'(enq_n) - CW'(deq_n);

        if (redirect) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            fpc_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed through the count.
    always_ff @(posedge clk) begin
        if (enq_n != 2'd0) begin
            mem_q[tail_q] <= imem_data1;
            mpc_q[tail_q] <= fpc_q;
        end
        if (enq_n == 2'd2) begin
            mem_q[tail_q + PW'(1)] <= imem_data2;
            mpc_q[tail_q + PW'(1)] <= fpc_q + ADDR_W'(1);
        end
    end

    assign q_count    = count_q;
    assign deq_valid0 = (count_q != '0);
    assign deq_valid1 = (count_q >= CW'(2));
    assign deq_inst0  = deq_valid0 ? mem_q[head_q] : '0;
    assign deq_inst1  = deq_valid1 ? mem_q[head_q + PW'(1)] : '0;
    assign deq_pc0    = deq_valid0 ? mpc_q[head_q] : '0;
    assign deq_pc1    = deq_valid1 ? mpc_q[head_q + PW'(1)] : '0;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a registered 16-word instruction memory model.
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, fetch_en, redirect;
    logic [3:0]  redirect_pc;
    logic [3:0]  imem_addr1, imem_addr2;
    logic [31:0] imem_data1, imem_data2;
    logic        deq_valid0, deq_valid1;
    logic [31:0] deq_inst0, deq_inst1;
    logic [3:0]  deq_pc0, deq_pc1;
    logic [1:0]  deq_count;
    logic [3:0]  q_count;
    logic        halted;

    logic [31:0] tb_mem [16];
    int checks = 0;
    int errors = 0;

    imem_fetch_ctrl dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr1(imem_addr1), .imem_addr2(imem_addr2),
        .imem_data1(imem_data1), .imem_data2(imem_data2),
        .deq_valid0(deq_valid0), .deq_valid1(deq_valid1),
        .deq_inst0(deq_inst0), .deq_inst1(deq_inst1),
        .deq_pc0(deq_pc0), .deq_pc1(deq_pc1), .deq_count(deq_count),
        .q_count(q_count), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_data1 <= tb_mem[imem_addr1];
        imem_data2 <= tb_mem[imem_addr2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 4'd0; deq_count = 2'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (deq_valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid0: got %0b expected 0", deq_valid0); end
        checks++; if (deq_valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %0b expected 0", deq_valid1); end
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL rst_qcount: got %0d expected 0", q_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b expected 0", halted); end
        checks++; if ({imem_addr1, imem_addr2} !== {4'd0, 4'd1}) begin errors++; $display("FAIL rst_addr: got %0d/%0d expected 0/1", imem_addr1, imem_addr2); end
        checks++; if ({deq_inst0, deq_pc0} !== 36'd0) begin errors++; $display("FAIL rst_deq_zero: got %0h/%0d expected 0/0", deq_inst0, deq_pc0); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en = 1'b1; deq_count = 2'd2;
        tick(); // C1: first issue 0/1
        checks++; if ({imem_addr1, imem_addr2} !== {4'd0, 4'd1}) begin errors++; $display("FAIL str_c1_addr: got %0d/%0d expected 0/1", imem_addr1, imem_addr2); end
        tick(); // C2
        checks++; if ({imem_addr1, imem_addr2} !== {4'd2, 4'd3}) begin errors++; $display("FAIL str_c2_addr: got %0d/%0d expected 2/3", imem_addr1, imem_addr2); end
        checks++; if (deq_valid0 !== 1'b0) begin errors++; $display("FAIL str_c2_valid0: got %0b expected 0", deq_valid0); end
        tick(); // C3: first dispatch
        checks++; if ({deq_valid0, deq_valid1} !== 2'b11) begin errors++; $display("FAIL str_c3_valid: got %b expected 11", {deq_valid0, deq_valid1}); end
        checks++; if ({deq_inst0, deq_inst1} !== {32'd0, 32'd1}) begin errors++; $display("FAIL str_c3_inst: got %0h/%0h expected 0/1", deq_inst0, deq_inst1); end
        checks++; if ({deq_pc0, deq_pc1} !== {4'd0, 4'd1}) begin errors++; $display("FAIL str_c3_pc: got %0d/%0d expected 0/1", deq_pc0, deq_pc1); end
        checks++; if (imem_addr1 !== 4'd4) begin errors++; $display("FAIL str_c3_addr: got %0d expected 4", imem_addr1); end
        tick(); // C4
        checks++; if ({deq_inst0, deq_inst1} !== {32'd2, 32'd3}) begin errors++; $display("FAIL str_c4_inst: got %0h/%0h expected 2/3", deq_inst0, deq_inst1); end
        checks++; if (q_count !== 4'd2) begin errors++; $display("FAIL str_c4_qcount: got %0d expected 2", q_count); end
        tick(); // C5
        checks++; if ({deq_inst0, deq_inst1, deq_pc0, deq_pc1} !== {32'd4, 32'd5, 4'd4, 4'd5}) begin errors++; $display("FAIL str_c5_deq: got %0h/%0h pc %0d/%0d expected 4/5 pc 4/5", deq_inst0, deq_inst1, deq_pc0, deq_pc1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1; deq_count = 2'd0;
        for (int i = 0; i < 5; i++) tick(); // C5: count 6, in-flight, no issue
        checks++; if ({q_count, imem_addr1} !== {4'd6, 4'd8}) begin errors++; $display("FAIL bp_c5: got q %0d addr %0d expected q 6 addr 8", q_count, imem_addr1); end
        tick(); // C6
        checks++; if ({q_count, imem_addr1} !== {4'd8, 4'd8}) begin errors++; $display("FAIL bp_c6: got q %0d addr %0d expected q 8 addr 8", q_count, imem_addr1); end
        tick(); // C7: still stalled
        checks++; if ({q_count, imem_addr1} !== {4'd8, 4'd8}) begin errors++; $display("FAIL bp_c7: got q %0d addr %0d expected q 8 addr 8", q_count, imem_addr1); end
        deq_count = 2'd1;
        tick(); // C8
        checks++; if ({q_count, imem_addr1} !== {4'd7, 4'd8}) begin errors++; $display("FAIL bp_c8: got q %0d addr %0d expected q 7 addr 8", q_count, imem_addr1); end
        checks++; if ({deq_inst0, deq_inst1} !== {32'd1, 32'd2}) begin errors++; $display("FAIL bp_c8_inst: got %0h/%0h expected 1/2", deq_inst0, deq_inst1); end
        tick(); // C9: issue resumes this cycle
        deq_count = 2'd0;
        checks++; if ({q_count, imem_addr1} !== {4'd6, 4'd8}) begin errors++; $display("FAIL bp_c9: got q %0d addr %0d expected q 6 addr 8", q_count, imem_addr1); end
        tick(); // C10
        checks++; if ({q_count, imem_addr1} !== {4'd6, 4'd10}) begin errors++; $display("FAIL bp_c10: got q %0d addr %0d expected q 6 addr 10", q_count, imem_addr1); end
        tick(); // C11
        checks++; if (q_count !== 4'd8) begin errors++; $display("FAIL bp_c11_qcount: got %0d expected 8", q_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 4'd14;
        tick();
        redirect = 1'b0;
        checks++; if ({imem_addr1, imem_addr2} !== {4'd14, 4'd15}) begin errors++; $display("FAIL wrap_idle_addr: got %0d/%0d expected 14/15", imem_addr1, imem_addr2); end
        fetch_en = 1'b1; deq_count = 2'd2;
        tick(); // issue 14/15
        checks++; if ({imem_addr1, imem_addr2} !== {4'd14, 4'd15}) begin errors++; $display("FAIL wrap_issue_addr: got %0d/%0d expected 14/15", imem_addr1, imem_addr2); end
        tick();
        checks++; if ({imem_addr1, imem_addr2} !== {4'd0, 4'd1}) begin errors++; $display("FAIL wrap_next_addr: got %0d/%0d expected 0/1", imem_addr1, imem_addr2); end
        tick();
        checks++; if ({deq_pc0, deq_pc1, deq_inst0, deq_inst1} !== {4'd14, 4'd15, 32'd14, 32'd15}) begin errors++; $display("FAIL wrap_deq_a: got pc %0d/%0d inst %0h/%0h expected 14/15", deq_pc0, deq_pc1, deq_inst0, deq_inst1); end
        tick();
        checks++; if ({deq_pc0, deq_pc1, deq_inst0, deq_inst1} !== {4'd0, 4'd1, 32'd0, 32'd1}) begin errors++; $display("FAIL wrap_deq_b: got pc %0d/%0d inst %0h/%0h expected 0/1", deq_pc0, deq_pc1, deq_inst0, deq_inst1); end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1; deq_count = 2'd0;
        for (int i = 0; i < 4; i++) tick(); // C4: q 4, pair 4/5 returning
        checks++; if (q_count !== 4'd4) begin errors++; $display("FAIL rd_pre_qcount: got %0d expected 4", q_count); end
        redirect = 1'b1; redirect_pc = 4'd5; deq_count = 2'd2;
        tick(); // C5
        redirect = 1'b0; deq_count = 2'd0;
        checks++; if ({q_count, deq_valid0} !== {4'd0, 1'b0}) begin errors++; $display("FAIL rd_c5_flush: got q %0d v0 %0b expected q 0 v0 0", q_count, deq_valid0); end
        checks++; if ({imem_addr1, imem_addr2} !== {4'd5, 4'd6}) begin errors++; $display("FAIL rd_c5_addr: got %0d/%0d expected 5/6", imem_addr1, imem_addr2); end
        tick(); // C6: stale pair must not appear
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL rd_c6_stale: got q %0d expected 0", q_count); end
        tick(); // C7
        checks++; if ({q_count, deq_inst0, deq_inst1} !== {4'd2, 32'd5, 32'd6}) begin errors++; $display("FAIL rd_c7_deq: got q %0d inst %0h/%0h expected q 2 inst 5/6", q_count, deq_inst0, deq_inst1); end
        checks++; if ({deq_pc0, deq_pc1} !== {4'd5, 4'd6}) begin errors++; $display("FAIL rd_c7_pc: got %0d/%0d expected 5/6", deq_pc0, deq_pc1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_en = 1'b1; deq_count = 2'd0;
        for (int i = 0; i < 5; i++) tick(); // C5: q 6 with pair in flight
        checks++; if (q_count !== 4'd6) begin errors++; $display("FAIL rm_pre_qcount: got %0d expected 6", q_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0; fetch_en = 1'b0;
        checks++; if ({q_count, deq_valid0, deq_valid1, halted} !== {4'd0, 3'b000}) begin errors++; $display("FAIL rm_state: got q %0d v %b%b h %0b expected q 0 v 00 h 0", q_count, deq_valid0, deq_valid1, halted); end
        checks++; if ({imem_addr1, deq_inst0, deq_pc0} !== {4'd0, 32'd0, 4'd0}) begin errors++; $display("FAIL rm_outputs: got addr %0d inst %0h pc %0d expected 0/0/0", imem_addr1, deq_inst0, deq_pc0); end
        tick();
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL rm_inflight_dropped: got %0d expected 0", q_count); end
    endtask

    task automatic test_halt();
        do_reset();
        tb_mem[3] = 32'hFFFF_FFFF;
        fetch_en = 1'b1; deq_count = 2'd0;
        for (int i = 0; i < 4; i++) tick(); // C4
`ifdef IMEM_FETCH_HALT_EN
        checks++; if ({halted, q_count, imem_addr1} !== {1'b1, 4'd4, 4'd4}) begin errors++; $display("FAIL halt_c4: got h %0b q %0d addr %0d expected h 1 q 4 addr 4", halted, q_count, imem_addr1); end
`else
        checks++; if ({halted, q_count, imem_addr1} !== {1'b0, 4'd4, 4'd6}) begin errors++; $display("FAIL nohalt_c4: got h %0b q %0d addr %0d expected h 0 q 4 addr 6", halted, q_count, imem_addr1); end
`endif
        deq_count = 2'd2;
        tick(); // C5
        deq_count = 2'd0;
        checks++; if ({deq_inst0, deq_inst1} !== {32'd2, 32'hFFFF_FFFF}) begin errors++; $display("FAIL halt_c5_inst: got %0h/%0h expected 2/ffffffff", deq_inst0, deq_inst1); end
`ifdef IMEM_FETCH_HALT_EN
        checks++; if ({halted, q_count, imem_addr1} !== {1'b1, 4'd2, 4'd4}) begin errors++; $display("FAIL halt_c5: got h %0b q %0d addr %0d expected h 1 q 2 addr 4", halted, q_count, imem_addr1); end
        redirect = 1'b1; redirect_pc = 4'd0;
        tick(); // C6
        redirect = 1'b0;
        checks++; if ({halted, q_count, imem_addr1} !== {1'b0, 4'd0, 4'd0}) begin errors++; $display("FAIL halt_c6: got h %0b q %0d addr %0d expected h 0 q 0 addr 0", halted, q_count, imem_addr1); end
        tick(); // C7
        checks++; if (imem_addr1 !== 4'd2) begin errors++; $display("FAIL halt_c7_restart: got %0d expected 2", imem_addr1); end
`else
        checks++; if ({halted, q_count} !== {1'b0, 4'd4}) begin errors++; $display("FAIL nohalt_c5: got h %0b q %0d expected h 0 q 4", halted, q_count); end
`endif
        tb_mem[3] = 32'd3;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tb_mem[i] = i;
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_redirect();
        test_reset_mid();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Dual-wide instruction fetch sequencer for the out-of-order Tomasulo core.
- Owns the PC and drives both read ports of the instruction memory (two 32-bit words per cycle, 1-cycle registered read latency).
- Buffers returned words in a fetch queue and presents up to two in-order instructions per cycle to dispatch.
- Handles branch redirect/flush and backpressure from dispatch.

Parameters:
- ADDR_W, 4, instruction-memory word-address width; PC wraps modulo 2^ADDR_W.
- DEPTH, 8, fetch-queue entries; power of two, minimum 4.
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits new fetches while high.
- redirect  input  1  one-cycle pulse; flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_W  new fetch word address.
- imem_addr1  output  ADDR_W  read address, port 1 (= pc).
- imem_addr2  output  ADDR_W  read address, port 2 (= pc+1, wrapped).
- imem_data1  input  DATA_W  word for imem_addr1, valid the cycle after issue.
- imem_data2  input  DATA_W  word for imem_addr2, valid the cycle after issue.
- deq_valid0  output  1  queue head valid.
- deq_valid1  output  1  head+1 valid.
- deq_inst0  output  DATA_W  instruction at head.
- deq_inst1  output  DATA_W  instruction at head+1.
- deq_pc0  output  ADDR_W  address of deq_inst0.
- deq_pc1  output  ADDR_W  address of deq_inst1.
- deq_count  input  2  instructions consumed this cycle (0, 1 or 2).
- q_count  output  $clog2(DEPTH)+1  current occupancy.
- halted  output  1  fetch stopped by halt detection; 0 when feature absent.

Behaviour:
- Reset values:
  - pc = 0, queue empty, in-flight flag = 0, state = IDLE.
  - All deq_valid = 0, q_count = 0, halted = 0.
  - deq_inst*/deq_pc* = 0 when not valid.
- Address generation: imem_addr1/imem_addr2 are combinational from the pc register. imem_addr2 = pc+1 mod 2^ADDR_W, so the pair at pc = 2^ADDR_W-1 is {last, 0}.
- FSM states: IDLE, FETCH, HALT.
  - IDLE -> FETCH when fetch_en = 1.
  - FETCH -> IDLE when fetch_en = 0. Any in-flight pair is still enqueued.
  - FETCH -> HALT only with the optional feature.
  - HALT -> FETCH on redirect.
  - redirect in IDLE sets pc; the state stays IDLE.
- Issue rule, cycle T: issue iff state = FETCH, fetch_en = 1, redirect = 0, and q_count + 2*inflight <= DEPTH-2 (registered values at cycle start; dequeue this cycle is ignored).
  - On issue: pc <= pc+2 (wrapped) and inflight <= 1; otherwise inflight <= 0.
- Return, cycle T+1: if inflight = 1 and no redirect, enqueue imem_data1 then imem_data2 with their PCs. Entries are visible at deq in T+2.
  - Issue-to-dispatch latency is 2 cycles.
  - Sustained throughput is 2 instructions per cycle when dispatch drains 2 per cycle.
- Dequeue: deq_count removes head entries in order. Values above the number of valid entries are clamped to that number; no underflow.
- Occupancy update: q_count_next = q_count + enq_n - deq_n, where enq_n is 0 or 2. Simultaneous enqueue and dequeue are legal. The queue never overflows, guaranteed by the issue rule.
- Queue pointers wrap modulo DEPTH. deq_valid1 requires q_count >= 2.
- Redirect (highest priority):
  - pc <= redirect_pc; the queue is flushed (q_count <= 0).
  - The in-flight pair is discarded: data returning in the redirect cycle or the next is not enqueued.
  - deq_count is ignored in the redirect cycle.
  - Fetch at redirect_pc issues no earlier than the next cycle.
- reset overrides redirect and everything else. Reset mid-fetch discards in-flight data.

Optional Feature:
- Macro: IMEM_FETCH_HALT_EN.
- Defined:
  - A returned word equal to 32'hFFFF_FFFF is a halt.
  - The halt word and all older words of that pair are enqueued; any younger word of that pair is dropped.
  - State -> HALT, halted = 1, no further issue until redirect. redirect clears halted.
- Undefined: all-ones is an ordinary instruction, the HALT state is unreachable, and halted is tied to 0.

Test Plan:
- Reset, fetch_en=1, deq_count=2 every cycle, memory word[i]=i -> imem_addr1/2 = 0/1, 2/3, ... in successive cycles. deq_valid0/1 first high 2 cycles after first issue with inst 0/1, pc 0/1, then 2/3 each following cycle.
- deq_count=0, DEPTH=8 -> issue stops when q_count + 2*inflight reaches 8. q_count saturates at 8 and pc stops at 8. Then deq_count=1 for two cycles -> fetch resumes.
- pc=14 with ADDR_W=4 -> addresses 14/15, then 0/1; deq_pc sequence 14, 15, 0, 1.
- redirect with redirect_pc=5 while a pair is in flight and q_count=4 -> next cycle q_count=0, stale pair not enqueued, addresses 5/6 issued; first deq shows inst 5/6.
- Assert reset for one cycle mid-stream with q_count=6 -> all outputs at reset values next cycle, pc=0.
- With IMEM_FETCH_HALT_EN, word[3]=FFFF_FFFF -> words 2 and 3 enqueued, then halted=1 and no further issue. redirect to 0 -> halted=0 and fetch restarts at 0.
